// File: rtl/cscfg_regbank_if.sv
// Command-bus interface shared by the per-FPGA config slaves.
// The master drives the request, and the slave returns rdata/ack one cycle later.
interface intf_cmd #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 8
) ();
    logic                 sel;
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] byte_addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 ack;

    modport master (output sel, rd_wr_n, byte_addr, wdata, input rdata, ack);
    modport slave  (input sel, rd_wr_n, byte_addr, wdata, output rdata, ack);
endinterface

// File: rtl/cscfg_regbank.sv
// CS configuration register bank: ID, status, sticky events with an IRQ mask, pulse strobes,
// an unmapped-access error counter and NUM_RW_REGS control registers behind intf_cmd.
module cscfg_regbank #(
    parameter logic [7:0]               FPGA_UID      = 8'h00,
    parameter logic [3:0]               REG_REV       = 4'h2,
    parameter int unsigned              CMD_DATA_BITS = 32,
    parameter int unsigned              NUM_RW_REGS   = 4,
    parameter int unsigned              NUM_EVENTS    = 8,
    parameter logic [CMD_DATA_BITS-1:0] RW_RESET      = '0
) (
    input  logic                                 i_sysclk,
    input  logic                                 i_arst,
    input  logic [CMD_DATA_BITS-1:0]             i_status,
    input  logic [NUM_EVENTS-1:0]                i_event,
    output logic [NUM_RW_REGS*CMD_DATA_BITS-1:0] o_ctrl,
    output logic [CMD_DATA_BITS-1:0]             o_pulse,
    output logic                                 o_irq,
    intf_cmd.slave                               cmd
);
    localparam int unsigned DW    = CMD_DATA_BITS;
    localparam int unsigned NE    = NUM_EVENTS;
    localparam int unsigned AW    = 8;
    localparam int unsigned WW    = AW - 2;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]    rw_q [NUM_RW_REGS];
    logic [DW-1:0]    rw_d [NUM_RW_REGS];
    logic [NE-1:0]    sticky_q, sticky_d;
    logic [NE-1:0]    irq_en_q, irq_en_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [DW-1:0]    pulse_q, pulse_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             ack_q;
    logic             irq_q, irq_d;

    logic [AW-1:0] addr;
    logic [WW-1:0] word;
    logic          aligned, rd, wr;
    logic          hit_id, hit_status, hit_sticky, hit_irq_en, hit_pulse, hit_err, hit_rw;
    logic          map_rd, map_wr, unmapped;
    logic [DW-1:0] rd_val;
    logic [NE-1:0] clr_mask;

    assign addr    = cmd.byte_addr;
    assign word    = addr[AW-1:2];
    assign aligned = (addr[1:0] == 2'b00);
    assign rd      = cmd.sel & cmd.rd_wr_n;
    assign wr      = cmd.sel & ~cmd.rd_wr_n;

    // Address decode over the word index; any misaligned byte address is unmapped.
    assign hit_id     = aligned && (word == WW'(0));
    assign hit_status = aligned && (word == WW'(1));
    assign hit_sticky = aligned && (word == WW'(2));
    assign hit_irq_en = aligned && (word == WW'(3));
    assign hit_pulse  = aligned && (word == WW'(4));
    assign hit_err    = aligned && (word == WW'(5));
    assign hit_rw     = aligned && (word >= WW'(8)) && (word < WW'(8 + NUM_RW_REGS));

    assign map_rd   = hit_id | hit_status | hit_sticky | hit_irq_en | hit_pulse | hit_err | hit_rw;
    assign map_wr   = hit_sticky | hit_irq_en | hit_pulse | hit_err | hit_rw;
    assign unmapped = cmd.sel && !(cmd.rd_wr_n ? map_rd : map_wr);

    // Read mux, sampled on the request cycle.
    always_comb begin
        rd_val = DW'(32'hDEADBEEF);
        if (hit_id) begin
            rd_val = DW'({20'h0, REG_REV, FPGA_UID});
        end else if (hit_status) begin
            rd_val = i_status;
        end else if (hit_sticky) begin
            rd_val = DW'(sticky_q);
        end else if (hit_irq_en) begin
            rd_val = DW'(irq_en_q);
        end else if (hit_pulse) begin
            rd_val = '0;
        end else if (hit_err) begin
            rd_val = DW'(err_q);
        end else if (hit_rw) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (word == WW'(8 + i)) begin
                    rd_val = rw_q[i];
                end
            end
        end
    end

    // Next-state for all bank registers.
    always_comb begin
        for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
            rw_d[i] = rw_q[i];
        end
        irq_en_d = irq_en_q;
        err_d    = err_q;
        pulse_d  = '0;
        rdata_d  = rdata_q;
        clr_mask = '0;

        if (rd) begin
            rdata_d = rd_val;
        end

        if (wr) begin
            if (hit_sticky) begin
                clr_mask = cmd.wdata[NE-1:0];
            end
            if (hit_irq_en) begin
                irq_en_d = cmd.wdata[NE-1:0];
            end
            if (hit_pulse) begin
                pulse_d = cmd.wdata;
            end
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (hit_rw && (word == WW'(8 + i))) begin
                    rw_d[i] = cmd.wdata;
                end
            end
        end

        // Clear on write takes priority; the clearing write is itself mapped.
        if (wr && hit_err) begin
            err_d = '0;
        end else if (unmapped && (err_q != CNT_MAX)) begin
            err_d = err_q + CNT_W'(1);
        end

        sticky_d = (sticky_q & ~clr_mask) | i_event;
        irq_d    = |(sticky_q & irq_en_q);
    end

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                rw_q[i] <= RW_RESET;
            end
            sticky_q <= '0;
            irq_en_q <= '0;
            err_q    <= '0;
            pulse_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                rw_q[i] <= rw_d[i];
            end
            sticky_q <= sticky_d;
            irq_en_q <= irq_en_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            rdata_q  <= rdata_d;
            ack_q    <= cmd.sel;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        o_ctrl = '0;
        for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
            o_ctrl[i*DW +: DW] = rw_q[i];
        end
    end

    assign o_pulse   = pulse_q;
    assign o_irq     = irq_q;
    assign cmd.rdata = rdata_q;
    assign cmd.ack   = ack_q;
endmodule

// File: tb/tb_cscfg_regbank.sv
// Self-checking bench for cscfg_regbank: directed register-map scenarios plus randomized
// traffic checked against an address-map reference model.
module tb_cscfg_regbank;
    localparam int unsigned NRW   = 4;
    localparam logic [31:0] RWRST = 32'hA5A5_0F0F;

    logic         clk = 1'b0;
    logic         arst;
    logic [31:0]  status;
    logic [7:0]   ev;
    logic [127:0] ctrl;
    logic [31:0]  pulse;
    logic         irq;

    intf_cmd #(.DATA_BITS(32), .ADDR_BITS(8)) cmd_if ();

    cscfg_regbank #(
        .FPGA_UID(8'h5A), .REG_REV(4'h2), .CMD_DATA_BITS(32),
        .NUM_RW_REGS(NRW), .NUM_EVENTS(8), .RW_RESET(RWRST)
    ) dut (
        .i_sysclk(clk), .i_arst(arst), .i_status(status), .i_event(ev),
        .o_ctrl(ctrl), .o_pulse(pulse), .o_irq(irq), .cmd(cmd_if.slave)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] m_rw [NRW];
    int          m_err;
    logic [7:0]  m_irqen;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag);
        for (int i = 0; i < NRW; i++) begin
            chk($sformatf("%s ctrl%0d", tag, i), ctrl[i*32 +: 32], m_rw[i]);
        end
    endtask

    // One transaction; returns at the negedge of the ack cycle.
    task automatic xact(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, input string tag);
        @(negedge clk);
        cmd_if.sel       = 1'b1;
        cmd_if.rd_wr_n   = !wr;
        cmd_if.byte_addr = a;
        cmd_if.wdata     = d;
        @(negedge clk);
        cmd_if.sel = 1'b0;
        chk({tag, " ack"}, 32'(cmd_if.ack), 32'd1);
        rd = cmd_if.rdata;
    endtask

    function automatic bit is_mapped(input logic [7:0] a, input bit wr);
        if (a[1:0] != 2'b00) return 1'b0;
        if (a == 8'h00 || a == 8'h04) return !wr;
        if (a == 8'h08 || a == 8'h0C || a == 8'h10 || a == 8'h14) return 1'b1;
        if (a >= 8'h20 && a < 8'h20 + 8'(4 * NRW)) return 1'b1;
        return 1'b0;
    endfunction

    // Expected read data with sticky flags known to be zero.
    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] st);
        if (!is_mapped(a, 1'b0)) return 32'hDEADBEEF;
        if (a >= 8'h20) return m_rw[int'(a - 8'h20) / 4];
        case (a)
            8'h00:   return 32'h0000_025A;
            8'h04:   return st;
            8'h0C:   return {24'h0, m_irqen};
            8'h14:   return 32'(m_err);
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] rd, exp_rd, d;
    logic [7:0]  a;
    bit          wr;
    logic [7:0]  pool [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                               8'h24, 8'h2C, 8'h30, 8'h40, 8'h03, 8'h0E};

    initial begin
        arst = 1'b1; status = 32'h0; ev = 8'h0;
        cmd_if.sel = 1'b0; cmd_if.rd_wr_n = 1'b1; cmd_if.byte_addr = 8'h0; cmd_if.wdata = 32'h0;
        for (int i = 0; i < NRW; i++) m_rw[i] = RWRST;
        m_err = 0; m_irqen = 8'h0;

        repeat (3) @(negedge clk);
        chk("rst ack", 32'(cmd_if.ack), 32'd0);
        chk("rst rdata", cmd_if.rdata, 32'h0);
        chk("rst pulse", pulse, 32'h0);
        chk("rst irq", 32'(irq), 32'd0);
        chk_ctrl("rst");
        arst = 1'b0;

        xact(1'b0, 8'h00, 32'h0, rd, "id");
        chk("id rdata", rd, 32'h0000_025A);
        xact(1'b0, 8'h20, 32'h0, rd, "rw0 rst");
        chk("rw0 rst rdata", rd, RWRST);

        xact(1'b1, 8'h24, 32'hCAFE_0001, rd, "wr rw1");
        chk("rdata held over write", rd, RWRST);
        m_rw[1] = 32'hCAFE_0001;
        chk_ctrl("wr rw1");
        xact(1'b0, 8'h24, 32'h0, rd, "rd rw1");
        chk("rw1 readback", rd, 32'hCAFE_0001);

        // Sticky event, mask and interrupt.
        @(negedge clk); ev = 8'h08;
        @(negedge clk); ev = 8'h00;
        xact(1'b1, 8'h0C, 32'h0000_0008, rd, "irq_en");
        @(negedge clk);
        chk("irq set", 32'(irq), 32'd1);
        xact(1'b0, 8'h08, 32'h0, rd, "sticky rd");
        chk("sticky set", rd, 32'h08);
        ev = 8'h08;
        xact(1'b1, 8'h08, 32'h08, rd, "w1c held");
        xact(1'b0, 8'h08, 32'h0, rd, "sticky rd2");
        chk("set wins", rd, 32'h08);
        chk("irq held", 32'(irq), 32'd1);
        ev = 8'h00;
        xact(1'b1, 8'h08, 32'h08, rd, "w1c");
        @(negedge clk);
        chk("irq cleared", 32'(irq), 32'd0);
        xact(1'b0, 8'h08, 32'h0, rd, "sticky rd3");
        chk("sticky cleared", rd, 32'h0);

        // Pulse strobe.
        xact(1'b1, 8'h10, 32'h0000_0005, rd, "pulse");
        chk("pulse on", pulse, 32'h5);
        @(negedge clk);
        chk("pulse off", pulse, 32'h0);
        xact(1'b0, 8'h10, 32'h0, rd, "pulse rd");
        chk("pulse reads 0", rd, 32'h0);

        // Unmapped accesses and error counter.
        xact(1'b0, 8'h40, 32'h0, rd, "unmap 40");
        chk("unmap 40 data", rd, 32'hDEADBEEF);
        xact(1'b0, 8'h06, 32'h0, rd, "unmap 06");
        chk("unmap 06 data", rd, 32'hDEADBEEF);
        xact(1'b1, 8'h00, 32'hFFFF_FFFF, rd, "wr id");
        xact(1'b0, 8'h00, 32'h0, rd, "id again");
        chk("id unchanged", rd, 32'h0000_025A);
        xact(1'b0, 8'h14, 32'h0, rd, "err rd");
        chk("err cnt 3", rd, 32'd3);
        xact(1'b1, 8'h14, 32'h0, rd, "err clr");
        xact(1'b0, 8'h14, 32'h0, rd, "err rd2");
        chk("err cleared", rd, 32'd0);
        last_rd = rd;

        // Randomized traffic against the address-map model.
        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
            d  = $urandom;
            status = $urandom;
            exp_rd = wr ? last_rd : model_read(a, status);
            xact(wr, a, d, rd, $sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d rdata a=%h w=%0d", t, a, wr), rd, exp_rd);
            chk($sformatf("rnd%0d pulse", t), pulse, (wr && a == 8'h10) ? d : 32'h0);
            if (wr && is_mapped(a, 1'b1)) begin
                if (a >= 8'h20) m_rw[int'(a - 8'h20) / 4] = d;
                else if (a == 8'h0C) m_irqen = d[7:0];
                else if (a == 8'h14) m_err = 0;
            end
            if (!is_mapped(a, wr)) m_err++;
            last_rd = rd;
            if (t % 10 == 9) chk_ctrl($sformatf("rnd%0d", t));
        end
        xact(1'b0, 8'h14, 32'h0, rd, "rnd err");
        chk("rnd err cnt", rd, 32'(m_err));
        xact(1'b0, 8'h0C, 32'h0, rd, "rnd irq_en");
        chk("rnd irq_en", rd, {24'h0, m_irqen});

        // Error counter saturation.
        xact(1'b1, 8'h14, 32'h0, rd, "sat clr");
        @(negedge clk);
        cmd_if.sel = 1'b1; cmd_if.rd_wr_n = 1'b1; cmd_if.byte_addr = 8'h40;
        repeat (65535) @(negedge clk);
        cmd_if.sel = 1'b0;
        xact(1'b0, 8'h14, 32'h0, rd, "sat rd");
        chk("err at max", rd, 32'h0000_FFFF);
        xact(1'b0, 8'h41, 32'h0, rd, "sat extra");
        xact(1'b0, 8'h14, 32'h0, rd, "sat rd2");
        chk("err saturated", rd, 32'h0000_FFFF);

        // Back-to-back transactions.
        @(negedge clk);
        cmd_if.sel = 1'b1; cmd_if.rd_wr_n = 1'b1; cmd_if.byte_addr = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) cmd_if.sel = 1'b0;
            chk($sformatf("b2b ack%0d", k), 32'(cmd_if.ack), 32'd1);
        end
        @(negedge clk);
        chk("b2b idle", 32'(cmd_if.ack), 32'd0);

        // Reset during the third of four back-to-back transactions.
        xact(1'b1, 8'h0C, 32'h08, rd, "pre irq_en");
        @(negedge clk); ev = 8'h08;
        @(negedge clk); ev = 8'h00;
        @(negedge clk);
        chk("pre irq", 32'(irq), 32'd1);
        cmd_if.sel = 1'b1; cmd_if.rd_wr_n = 1'b1; cmd_if.byte_addr = 8'h00;
        @(negedge clk);
        chk("rstx ack1", 32'(cmd_if.ack), 32'd1);
        @(negedge clk);
        chk("rstx ack2", 32'(cmd_if.ack), 32'd1);
        #2 arst = 1'b1;
        @(negedge clk);
        cmd_if.sel = 1'b0;
        chk("rstx ack3", 32'(cmd_if.ack), 32'd0);
        chk("rstx rdata", cmd_if.rdata, 32'h0);
        chk("rstx irq", 32'(irq), 32'd0);
        chk("rstx pulse", pulse, 32'h0);
        for (int i = 0; i < NRW; i++) m_rw[i] = RWRST;
        chk_ctrl("rstx");
        @(negedge clk); arst = 1'b0;
        @(negedge clk);
        chk("rstx no ack", 32'(cmd_if.ack), 32'd0);
        xact(1'b0, 8'h14, 32'h0, rd, "post err");
        chk("post err 0", rd, 32'h0);
        xact(1'b0, 8'h0C, 32'h0, rd, "post irq_en");
        chk("post irq_en 0", rd, 32'h0);
        xact(1'b0, 8'h08, 32'h0, rd, "post sticky");
        chk("post sticky 0", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/cscfg_regbank.md
# cscfg_regbank

Parametrised command-bus register bank for the CS configuration path: a slave on `intf_cmd` exposing an ID word, live status, sticky event flags with write-1-to-clear, an interrupt mask, self-clearing pulse strobes, an unmapped-access error counter and `NUM_RW_REGS` read/write control registers. It sits behind the command decoder, alongside the other per-FPGA config slaves. Its outputs drive control fabric and the config interrupt line.

## Interface
- `FPGA_UID`, 8'h00, FPGA identifier reported in ID word bits [7:0].
- `REG_REV`, 4'h2, register-map revision reported in ID word bits [11:8].
- `CMD_DATA_BITS`, 32, command data width; must be 32 or greater.
- `NUM_RW_REGS`, 4, number of RW control registers, 1..16.
- `NUM_EVENTS`, 8, number of sticky event inputs, 1..CMD_DATA_BITS.
- `RW_RESET`, 0, reset value of every RW register (CMD_DATA_BITS wide).
- `i_sysclk`  in  1  system clock; the only clock.
- `i_arst`  in  1  asynchronous, active-high reset.
- `i_status`  in  CMD_DATA_BITS  live status, already synchronous to `i_sysclk`.
- `i_event`  in  NUM_EVENTS  event inputs, level-sampled every cycle.
- `o_ctrl`  out  NUM_RW_REGS*CMD_DATA_BITS  RW registers, flattened; reg i at [i*CMD_DATA_BITS +: CMD_DATA_BITS].
- `o_pulse`  out  CMD_DATA_BITS  one-cycle strobes.
- `o_irq`  out  1  registered interrupt request.
- `cmd`  intf_cmd.slave  —  members used: `sel`, `rd_wr_n`, `byte_addr`, `wdata` (in); `rdata`, `ack` (out).

## Operation
- Address map (byte addresses):
  - 0x00 ID (RO): bits [7:0] FPGA_UID, bits [11:8] REG_REV, remaining bits 0.
  - 0x04 STATUS (RO): `i_status`.
  - 0x08 STICKY (W1C): bit k sets while `i_event[k]`=1; a write clears the bits where wdata=1. Set wins over clear in the same cycle. Bits ≥ NUM_EVENTS read 0.
  - 0x0C IRQ_EN (RW): mask, NUM_EVENTS bits wide; upper bits read 0.
  - 0x10 PULSE (WO): a write drives `o_pulse`=wdata for exactly one cycle; reads return 0.
  - 0x14 ERR_CNT (RO, write-any-clears): 16-bit count of unmapped accesses, saturating at 0xFFFF; upper bits read 0.
  - 0x20+4*i RW reg i, for i < NUM_RW_REGS.
- Unmapped means any other address, any address with `byte_addr[1:0]`≠0, or a write to a RO register (ID, STATUS). Unmapped reads return 32'hDEADBEEF, zero-extended to CMD_DATA_BITS. Every unmapped read or write increments ERR_CNT.
- A write to ERR_CNT clears it; that write is mapped and does not count.
- `o_irq` is registered |(STICKY & IRQ_EN).
- Writes to RO registers do not change them.

## Timing
- Each cycle with `sel`=1 is one transaction. Back-to-back `sel` is legal and gives one ack per cycle.
- `ack` is asserted the cycle after `sel`, for one cycle. `rdata` is valid in the ack cycle and held until the next read.
- Write effects are visible in the ack cycle. `o_pulse` is high in the ack cycle only.
- STICKY set: `i_event` high at edge n makes the bit 1 after edge n. `o_irq` rises one cycle later.
- Reset values: `ack` 0, `rdata` 0, `o_ctrl` RW_RESET, STICKY 0, IRQ_EN 0, `o_pulse` 0, ERR_CNT 0, `o_irq` 0.
- Reset asserted mid-transaction: the transaction is dropped and no ack is issued.

## Test plan
- Reset, then read 0x00 with FPGA_UID=8'h5A, REG_REV=2 → ack one cycle later, rdata=32'h0000025A; read 0x20 → RW_RESET.
- Write 0x24=32'hCAFE0001, then read it back → o_ctrl reg1=32'hCAFE0001, readback matches; other RW regs unchanged.
- Pulse `i_event[3]`, set IRQ_EN=8'h08 → STICKY=0x08 and o_irq=1. Write 0x08=0x08 while `i_event[3]` is held high → bit stays 1. Release the event and write again → STICKY=0, o_irq=0 next cycle.
- Write 0x10=32'h00000005 → o_pulse=5 for exactly one cycle, then 0; read 0x10 → 0.
- Read 0x40, read 0x06, write 0x00 → rdata=DEADBEEF for the two reads, ID unchanged, ERR_CNT=3. Write 0x14 → ERR_CNT=0. Force the count to 0xFFFF, then one more unmapped access → stays 0xFFFF.
- Issue `sel` on 4 consecutive cycles → 4 consecutive acks. Assert `i_arst` during the 3rd → no further ack, all outputs at reset values.
